// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit for the five-stage MIPS core.
// Decodes the ID instruction and carries its control bundle through EX/MEM/WB.
// Detects load-use and branch/jr operand hazards and resolves jumps in ID.
module pipe_ctrl_unit #(
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic [REG_AW-1:0] rd,
  input  logic              operands_eq,
  output logic              stall,
  output logic              if_flush,
  output logic [1:0]        pc_src,
  output logic              ex_alu_src,
  output logic [2:0]        ex_alu_op,
  output logic              ex_valid,
  output logic              mem_read,
  output logic              mem_write,
  output logic [REG_AW-1:0] mem_dst,
  output logic              wb_reg_write,
  output logic [1:0]        wb_mem_to_reg,
  output logic [REG_AW-1:0] wb_dst,
  output logic              illegal
);

  if (REG_AW < 5) begin : g_aw_check
    $error("pipe_ctrl_unit: REG_AW must be >= 5");
  end

  typedef enum logic [5:0] {
    OP_R    = 6'b000000,
    OP_J    = 6'b000010,
    OP_JAL  = 6'b000011,
    OP_BEQ  = 6'b000100,
    OP_JR   = 6'b000110,
    OP_ADDI = 6'b001001,
    OP_SLTI = 6'b001010,
    OP_LW   = 6'b100011,
    OP_SW   = 6'b101011
  } opcode_e;

  typedef enum logic [5:0] {
    FN_NOP = 6'b000000,
    FN_ADD = 6'b100000,
    FN_SUB = 6'b100010,
    FN_AND = 6'b100100,
    FN_OR  = 6'b100101,
    FN_SLT = 6'b101010
  } funct_e;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_BR  = 2'b01,
    PC_JMP = 2'b10,
    PC_REG = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_LINK = 2'b10
  } wb_sel_e;

  typedef struct packed {
    logic              valid;
    logic              alu_src;
    logic [2:0]        alu_op;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic [1:0]        mem_to_reg;
    logic [REG_AW-1:0] dst;
  } ex_ctrl_t;

  typedef struct packed {
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic [1:0]        mem_to_reg;
    logic [REG_AW-1:0] dst;
  } mem_ctrl_t;

  typedef struct packed {
    logic              reg_write;
    logic [1:0]        mem_to_reg;
    logic [REG_AW-1:0] dst;
  } wb_ctrl_t;

  ex_ctrl_t  dec;
  ex_ctrl_t  ex_q, ex_d;
  mem_ctrl_t mem_q, mem_d;
  wb_ctrl_t  wb_q, wb_d;
  logic      illegal_q, illegal_d;
  logic      uses_rs, uses_rt, is_beq, is_jr, is_jump, dec_illegal;
  logic      src_hit_ex, src_hit_mem;
  pc_sel_e   pc_sel;

  // Decode the ID instruction into its control bundle and source usage.
  always_comb begin
    dec         = '0;
    dec.valid   = 1'b1;
    uses_rs     = 1'b0;
    uses_rt     = 1'b0;
    is_beq      = 1'b0;
    is_jr       = 1'b0;
    is_jump     = 1'b0;
    dec_illegal = 1'b0;
    case (opcode)
      OP_R: begin
        uses_rs       = 1'b1;
        uses_rt       = 1'b1;
        dec.dst       = rd;
        dec.reg_write = 1'b1;
        case (funct)
          FN_ADD:  dec.alu_op = ALU_ADD;
          FN_SUB:  dec.alu_op = ALU_SUB;
          FN_AND:  dec.alu_op = ALU_AND;
          FN_OR:   dec.alu_op = ALU_OR;
          FN_SLT:  dec.alu_op = ALU_SLT;
          FN_NOP:  dec.reg_write = 1'b0;
          default: begin
            dec.reg_write = 1'b0;
            dec_illegal   = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_SLTI: begin
        uses_rs       = 1'b1;
        dec.dst       = rt;
        dec.alu_src   = 1'b1;
        dec.alu_op    = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
        dec.reg_write = 1'b1;
      end
      OP_LW: begin
        uses_rs        = 1'b1;
        dec.dst        = rt;
        dec.alu_src    = 1'b1;
        dec.alu_op     = ALU_ADD;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = WB_MEM;
        dec.reg_write  = 1'b1;
      end
      OP_SW: begin
        uses_rs       = 1'b1;
        uses_rt       = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = ALU_ADD;
        dec.mem_write = 1'b1;
      end
      OP_J:   is_jump = 1'b1;
      OP_JAL: begin
        is_jump        = 1'b1;
        dec.dst        = '1;
        dec.mem_to_reg = WB_LINK;
        dec.reg_write  = 1'b1;
      end
      OP_JR: begin
        uses_rs = 1'b1;
        is_jr   = 1'b1;
      end
      OP_BEQ: begin
        uses_rs = 1'b1;
        uses_rt = 1'b1;
        is_beq  = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
    if (dec.dst == '0) dec.reg_write = 1'b0;
  end

  // Hazard detection: register 0 never matches.
  always_comb begin
    src_hit_ex  = (uses_rs && rs != '0 && rs == ex_q.dst) ||
                  (uses_rt && rt != '0 && rt == ex_q.dst);
    src_hit_mem = (uses_rs && rs != '0 && rs == mem_q.dst) ||
                  (uses_rt && rt != '0 && rt == mem_q.dst);
    stall = (ex_q.mem_read && src_hit_ex) ||
            ((is_beq || is_jr) &&
             ((ex_q.reg_write && src_hit_ex) || (mem_q.mem_read && src_hit_mem)));
  end

  // PC select / IF flush and next-state for the pipeline registers.
  always_comb begin
    pc_sel   = PC_SEQ;
    if_flush = 1'b0;
    if (!stall) begin
      if (is_beq && operands_eq) begin
        pc_sel   = PC_BR;
        if_flush = 1'b1;
      end else if (is_jump) begin
        pc_sel   = PC_JMP;
        if_flush = 1'b1;
      end else if (is_jr) begin
        pc_sel   = PC_REG;
        if_flush = 1'b1;
      end
    end
    ex_d      = stall ? '0 : dec;
    mem_d     = '{mem_read: ex_q.mem_read, mem_write: ex_q.mem_write,
                  reg_write: ex_q.reg_write, mem_to_reg: ex_q.mem_to_reg, dst: ex_q.dst};
    wb_d      = '{reg_write: mem_q.reg_write, mem_to_reg: mem_q.mem_to_reg, dst: mem_q.dst};
    illegal_d = illegal_q | (dec_illegal & ~stall);
  end

  // Pipeline and sticky-flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      ex_q      <= ex_d;
      mem_q     <= mem_d;
      wb_q      <= wb_d;
      illegal_q <= illegal_d;
    end
  end

  assign pc_src        = pc_sel;
  assign ex_alu_src    = ex_q.alu_src;
  assign ex_alu_op     = ex_q.alu_op;
  assign ex_valid      = ex_q.valid;
  assign mem_read      = mem_q.mem_read;
  assign mem_write     = mem_q.mem_write;
  assign mem_dst       = mem_q.dst;
  assign wb_reg_write  = wb_q.reg_write;
  assign wb_mem_to_reg = wb_q.mem_to_reg;
  assign wb_dst        = wb_q.dst;
  assign illegal       = illegal_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: per-scenario instruction tables,
// expected stage bundles queued at issue and popped as they reach EX/MEM/WB.
module tb_pipe_ctrl_unit;

  logic       clk, rst;
  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd;
  logic       operands_eq;
  logic       stall, if_flush;
  logic [1:0] pc_src;
  logic       ex_alu_src;
  logic [2:0] ex_alu_op;
  logic       ex_valid;
  logic       mem_read, mem_write;
  logic [4:0] mem_dst;
  logic       wb_reg_write;
  logic [1:0] wb_mem_to_reg;
  logic [4:0] wb_dst;
  logic       illegal;

  pipe_ctrl_unit #(.REG_AW(5)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
    .rs(rs), .rt(rt), .rd(rd), .operands_eq(operands_eq),
    .stall(stall), .if_flush(if_flush), .pc_src(pc_src),
    .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op), .ex_valid(ex_valid),
    .mem_read(mem_read), .mem_write(mem_write), .mem_dst(mem_dst),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_dst(wb_dst),
    .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [5:0] R = 6'b000000, ADDI = 6'b001001, SLTI = 6'b001010,
                         LW = 6'b100011, SW = 6'b101011, J = 6'b000010,
                         JAL = 6'b000011, JR = 6'b000110, BEQ = 6'b000100,
                         BAD = 6'b111111;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100,
                         F_OR = 6'b100101, F_SLT = 6'b101010, F_NOP = 6'b000000,
                         F_BAD = 6'b000111;

  typedef struct packed {
    logic       valid;
    logic       alu_src;
    logic [2:0] alu_op;
    logic       mr;
    logic       mw;
    logic       rw;
    logic [1:0] m2r;
    logic [4:0] dst;
  } bnd_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       eq;
    logic [3:0] cmb;  // {stall, pc_src, if_flush}
    logic       ill;  // illegal expected after the edge
    logic       rst;
  } row_t;

  localparam bnd_t BUBBLE = '0;

  int   n_cmp = 0;
  int   n_err = 0;
  bnd_t exq[$], memq[$], wbq[$];

  function automatic row_t mk(input logic [5:0] op, input logic [5:0] fn, input int s,
                              input int tt, input int d, input int eq,
                              input logic [3:0] cmb, input int ill);
    row_t r;
    r.op = op; r.fn = fn; r.rs = 5'(s); r.rt = 5'(tt); r.rd = 5'(d);
    r.eq = 1'(eq); r.cmb = cmb; r.ill = 1'(ill); r.rst = 1'b0;
    return r;
  endfunction

  function automatic row_t nop(input int ill);
    return mk(R, F_NOP, 0, 0, 0, 0, 4'b0000, ill);
  endfunction

  // Expected control bundle for a non-stalled instruction.
  function automatic bnd_t exp_bundle(input logic [5:0] op, input logic [5:0] fn,
                                      input logic [4:0] trg, input logic [4:0] dreg);
    bnd_t b = '0;
    b.valid = 1'b1;
    case (op)
      R: begin
        b.dst = dreg; b.rw = 1'b1;
        if (fn == F_ADD)      b.alu_op = 3'b010;
        else if (fn == F_SUB) b.alu_op = 3'b110;
        else if (fn == F_AND) b.alu_op = 3'b000;
        else if (fn == F_OR)  b.alu_op = 3'b001;
        else if (fn == F_SLT) b.alu_op = 3'b111;
        else                  b.rw = 1'b0;
      end
      ADDI: begin b.dst = trg; b.alu_src = 1'b1; b.alu_op = 3'b010; b.rw = 1'b1; end
      SLTI: begin b.dst = trg; b.alu_src = 1'b1; b.alu_op = 3'b111; b.rw = 1'b1; end
      LW:   begin b.dst = trg; b.alu_src = 1'b1; b.alu_op = 3'b010; b.mr = 1'b1;
                  b.m2r = 2'b01; b.rw = 1'b1; end
      SW:   begin b.alu_src = 1'b1; b.alu_op = 3'b010; b.mw = 1'b1; end
      JAL:  begin b.dst = 5'd31; b.m2r = 2'b10; b.rw = 1'b1; end
      default: ;
    endcase
    if (b.dst == 5'd0) b.rw = 1'b0;
    return b;
  endfunction

  // ALU fields only matter for instructions that use the ALU result.
  function automatic logic [4:0] ex_mask(input bnd_t b);
    return (b.mr || b.mw || (b.rw && b.m2r != 2'b10)) ? 5'h1F : 5'h10;
  endfunction
  function automatic logic [6:0] mem_mask(input bnd_t b);
    return (b.rw || b.mr) ? 7'h7F : 7'h60;
  endfunction
  function automatic logic [7:0] wb_mask(input bnd_t b);
    return b.rw ? 8'hFF : 8'h80;
  endfunction

  task automatic test_reset();
    rst = 1'b1; opcode = R; funct = F_NOP; rs = '0; rt = '0; rd = '0; operands_eq = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({ex_valid, ex_alu_src, ex_alu_op, mem_read, mem_write, mem_dst,
         wb_reg_write, wb_mem_to_reg, wb_dst, illegal} !== '0) begin
      n_err++;
      $display("FAIL reset_regs: got %b want 0", {ex_valid, ex_alu_src, ex_alu_op, mem_read,
               mem_write, mem_dst, wb_reg_write, wb_mem_to_reg, wb_dst, illegal});
    end
    n_cmp++;
    if ({stall, pc_src, if_flush} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_comb: got %b want 0000", {stall, pc_src, if_flush});
    end
    rst = 1'b0;
    exq.delete(); memq.delete(); wbq.delete();
    memq.push_back(BUBBLE);
    wbq.push_back(BUBBLE); wbq.push_back(BUBBLE);
  endtask

  task automatic test_alu();
    row_t t[$]; bnd_t e; logic [4:0] m5; logic [6:0] m7; logic [7:0] m8;
    t.push_back(nop(0)); t.push_back(nop(0));
    t.push_back(mk(R, F_ADD, 1, 2, 3, 0, 4'b0000, 0));
    t.push_back(mk(R, F_SUB, 3, 4, 5, 0, 4'b0000, 0));
    t.push_back(mk(R, F_AND, 1, 2, 6, 0, 4'b0000, 0));
    t.push_back(mk(R, F_OR,  1, 2, 7, 0, 4'b0000, 0));
    t.push_back(mk(R, F_SLT, 1, 2, 8, 0, 4'b0000, 0));
    t.push_back(mk(ADDI, 0, 1, 9, 0, 0, 4'b0000, 0));
    t.push_back(mk(SLTI, 0, 1, 10, 0, 0, 4'b0000, 0));
    t.push_back(mk(SW, 0, 1, 2, 0, 0, 4'b0000, 0));
    t.push_back(mk(ADDI, 0, 1, 0, 0, 0, 4'b0000, 0));
    repeat (3) t.push_back(nop(0));
    foreach (t[i]) begin
      opcode = t[i].op; funct = t[i].fn; rs = t[i].rs; rt = t[i].rt; rd = t[i].rd;
      operands_eq = t[i].eq;
      #2;
      n_cmp++;
      if ({stall, pc_src, if_flush} !== t[i].cmb) begin
        n_err++; $display("FAIL alu comb row %0d: got %b want %b", i, {stall, pc_src, if_flush}, t[i].cmb);
      end
      e = t[i].cmb[3] ? BUBBLE : exp_bundle(t[i].op, t[i].fn, t[i].rt, t[i].rd);
      exq.push_back(e); memq.push_back(e); wbq.push_back(e);
      @(posedge clk); #1;
      e = exq.pop_front(); m5 = ex_mask(e); n_cmp++;
      if (({ex_valid, ex_alu_src, ex_alu_op} & m5) !== ({e.valid, e.alu_src, e.alu_op} & m5)) begin
        n_err++; $display("FAIL alu ex row %0d: got %b want %b", i, {ex_valid, ex_alu_src, ex_alu_op}, {e.valid, e.alu_src, e.alu_op});
      end
      e = memq.pop_front(); m7 = mem_mask(e); n_cmp++;
      if (({mem_read, mem_write, mem_dst} & m7) !== ({e.mr, e.mw, e.dst} & m7)) begin
        n_err++; $display("FAIL alu mem row %0d: got %b want %b", i, {mem_read, mem_write, mem_dst}, {e.mr, e.mw, e.dst});
      end
      e = wbq.pop_front(); m8 = wb_mask(e); n_cmp++;
      if (({wb_reg_write, wb_mem_to_reg, wb_dst} & m8) !== ({e.rw, e.m2r, e.dst} & m8)) begin
        n_err++; $display("FAIL alu wb row %0d: got %b want %b", i, {wb_reg_write, wb_mem_to_reg, wb_dst}, {e.rw, e.m2r, e.dst});
      end
      n_cmp++;
      if (illegal !== t[i].ill) begin
        n_err++; $display("FAIL alu illegal row %0d: got %b want %b", i, illegal, t[i].ill);
      end
    end
  endtask

  task automatic test_load_use();
    row_t t[$]; bnd_t e; logic [4:0] m5; logic [6:0] m7; logic [7:0] m8;
    t.push_back(nop(0)); t.push_back(nop(0));
    t.push_back(mk(LW, 0, 1, 5, 0, 0, 4'b0000, 0));
    t.push_back(mk(R, F_ADD, 5, 2, 6, 0, 4'b1000, 0));
    t.push_back(mk(R, F_ADD, 5, 2, 6, 0, 4'b0000, 0));
    t.push_back(mk(LW, 0, 1, 7, 0, 0, 4'b0000, 0));
    t.push_back(mk(SW, 0, 2, 7, 0, 0, 4'b1000, 0));
    t.push_back(mk(SW, 0, 2, 7, 0, 0, 4'b0000, 0));
    t.push_back(mk(LW, 0, 1, 7, 0, 0, 4'b0000, 0));
    t.push_back(mk(ADDI, 0, 2, 7, 0, 0, 4'b0000, 0));
    t.push_back(mk(LW, 0, 1, 0, 0, 0, 4'b0000, 0));
    t.push_back(mk(R, F_ADD, 0, 0, 9, 0, 4'b0000, 0));
    repeat (3) t.push_back(nop(0));
    foreach (t[i]) begin
      opcode = t[i].op; funct = t[i].fn; rs = t[i].rs; rt = t[i].rt; rd = t[i].rd;
      operands_eq = t[i].eq;
      #2;
      n_cmp++;
      if ({stall, pc_src, if_flush} !== t[i].cmb) begin
        n_err++; $display("FAIL load_use comb row %0d: got %b want %b", i, {stall, pc_src, if_flush}, t[i].cmb);
      end
      e = t[i].cmb[3] ? BUBBLE : exp_bundle(t[i].op, t[i].fn, t[i].rt, t[i].rd);
      exq.push_back(e); memq.push_back(e); wbq.push_back(e);
      @(posedge clk); #1;
      e = exq.pop_front(); m5 = ex_mask(e); n_cmp++;
      if (({ex_valid, ex_alu_src, ex_alu_op} & m5) !== ({e.valid, e.alu_src, e.alu_op} & m5)) begin
        n_err++; $display("FAIL load_use ex row %0d: got %b want %b", i, {ex_valid, ex_alu_src, ex_alu_op}, {e.valid, e.alu_src, e.alu_op});
      end
      e = memq.pop_front(); m7 = mem_mask(e); n_cmp++;
      if (({mem_read, mem_write, mem_dst} & m7) !== ({e.mr, e.mw, e.dst} & m7)) begin
        n_err++; $display("FAIL load_use mem row %0d: got %b want %b", i, {mem_read, mem_write, mem_dst}, {e.mr, e.mw, e.dst});
      end
      e = wbq.pop_front(); m8 = wb_mask(e); n_cmp++;
      if (({wb_reg_write, wb_mem_to_reg, wb_dst} & m8) !== ({e.rw, e.m2r, e.dst} & m8)) begin
        n_err++; $display("FAIL load_use wb row %0d: got %b want %b", i, {wb_reg_write, wb_mem_to_reg, wb_dst}, {e.rw, e.m2r, e.dst});
      end
    end
  endtask

  task automatic test_branch_hazard();
    row_t t[$]; bnd_t e; logic [4:0] m5; logic [6:0] m7; logic [7:0] m8;
    t.push_back(nop(0)); t.push_back(nop(0));
    t.push_back(mk(LW, 0, 1, 4, 0, 0, 4'b0000, 0));
    t.push_back(mk(BEQ, 0, 4, 2, 0, 1, 4'b1000, 0));
    t.push_back(mk(BEQ, 0, 4, 2, 0, 1, 4'b1000, 0));
    t.push_back(mk(BEQ, 0, 4, 2, 0, 1, 4'b0011, 0));
    t.push_back(nop(0));
    t.push_back(mk(R, F_ADD, 1, 2, 8, 0, 4'b0000, 0));
    t.push_back(mk(BEQ, 0, 1, 8, 0, 0, 4'b1000, 0));
    t.push_back(mk(BEQ, 0, 1, 8, 0, 0, 4'b0000, 0));
    t.push_back(mk(R, F_ADD, 1, 2, 8, 0, 4'b0000, 0));
    t.push_back(nop(0));
    t.push_back(mk(BEQ, 0, 1, 8, 0, 1, 4'b0011, 0));
    t.push_back(mk(LW, 0, 1, 0, 0, 0, 4'b0000, 0));
    t.push_back(mk(BEQ, 0, 0, 0, 0, 1, 4'b0011, 0));
    repeat (2) t.push_back(nop(0));
    foreach (t[i]) begin
      opcode = t[i].op; funct = t[i].fn; rs = t[i].rs; rt = t[i].rt; rd = t[i].rd;
      operands_eq = t[i].eq;
      #2;
      n_cmp++;
      if ({stall, pc_src, if_flush} !== t[i].cmb) begin
        n_err++; $display("FAIL branch comb row %0d: got %b want %b", i, {stall, pc_src, if_flush}, t[i].cmb);
      end
      e = t[i].cmb[3] ? BUBBLE : exp_bundle(t[i].op, t[i].fn, t[i].rt, t[i].rd);
      exq.push_back(e); memq.push_back(e); wbq.push_back(e);
      @(posedge clk); #1;
      e = exq.pop_front(); m5 = ex_mask(e); n_cmp++;
      if (({ex_valid, ex_alu_src, ex_alu_op} & m5) !== ({e.valid, e.alu_src, e.alu_op} & m5)) begin
        n_err++; $display("FAIL branch ex row %0d: got %b want %b", i, {ex_valid, ex_alu_src, ex_alu_op}, {e.valid, e.alu_src, e.alu_op});
      end
      e = memq.pop_front(); m7 = mem_mask(e); n_cmp++;
      if (({mem_read, mem_write, mem_dst} & m7) !== ({e.mr, e.mw, e.dst} & m7)) begin
        n_err++; $display("FAIL branch mem row %0d: got %b want %b", i, {mem_read, mem_write, mem_dst}, {e.mr, e.mw, e.dst});
      end
      e = wbq.pop_front(); m8 = wb_mask(e); n_cmp++;
      if (({wb_reg_write, wb_mem_to_reg, wb_dst} & m8) !== ({e.rw, e.m2r, e.dst} & m8)) begin
        n_err++; $display("FAIL branch wb row %0d: got %b want %b", i, {wb_reg_write, wb_mem_to_reg, wb_dst}, {e.rw, e.m2r, e.dst});
      end
    end
  endtask

  task automatic test_jumps();
    row_t t[$]; bnd_t e; logic [4:0] m5; logic [6:0] m7; logic [7:0] m8;
    t.push_back(nop(0)); t.push_back(nop(0));
    t.push_back(mk(JAL, 0, 0, 0, 0, 0, 4'b0101, 0));
    t.push_back(mk(JR, 0, 31, 0, 0, 0, 4'b1000, 0));
    t.push_back(mk(JR, 0, 31, 0, 0, 0, 4'b0111, 0));
    t.push_back(nop(0));
    t.push_back(mk(J, 0, 0, 0, 0, 0, 4'b0101, 0));
    t.push_back(mk(JR, 0, 7, 0, 0, 0, 4'b0111, 0));
    t.push_back(mk(BEQ, 0, 1, 2, 0, 0, 4'b0000, 0));
    t.push_back(mk(BEQ, 0, 1, 2, 0, 1, 4'b0011, 0));
    repeat (3) t.push_back(nop(0));
    foreach (t[i]) begin
      opcode = t[i].op; funct = t[i].fn; rs = t[i].rs; rt = t[i].rt; rd = t[i].rd;
      operands_eq = t[i].eq;
      #2;
      n_cmp++;
      if ({stall, pc_src, if_flush} !== t[i].cmb) begin
        n_err++; $display("FAIL jumps comb row %0d: got %b want %b", i, {stall, pc_src, if_flush}, t[i].cmb);
      end
      e = t[i].cmb[3] ? BUBBLE : exp_bundle(t[i].op, t[i].fn, t[i].rt, t[i].rd);
      exq.push_back(e); memq.push_back(e); wbq.push_back(e);
      @(posedge clk); #1;
      e = exq.pop_front(); m5 = ex_mask(e); n_cmp++;
      if (({ex_valid, ex_alu_src, ex_alu_op} & m5) !== ({e.valid, e.alu_src, e.alu_op} & m5)) begin
        n_err++; $display("FAIL jumps ex row %0d: got %b want %b", i, {ex_valid, ex_alu_src, ex_alu_op}, {e.valid, e.alu_src, e.alu_op});
      end
      e = memq.pop_front(); m7 = mem_mask(e); n_cmp++;
      if (({mem_read, mem_write, mem_dst} & m7) !== ({e.mr, e.mw, e.dst} & m7)) begin
        n_err++; $display("FAIL jumps mem row %0d: got %b want %b", i, {mem_read, mem_write, mem_dst}, {e.mr, e.mw, e.dst});
      end
      e = wbq.pop_front(); m8 = wb_mask(e); n_cmp++;
      if (({wb_reg_write, wb_mem_to_reg, wb_dst} & m8) !== ({e.rw, e.m2r, e.dst} & m8)) begin
        n_err++; $display("FAIL jumps wb row %0d: got %b want %b", i, {wb_reg_write, wb_mem_to_reg, wb_dst}, {e.rw, e.m2r, e.dst});
      end
    end
  endtask

  task automatic test_illegal(input bit funct_case);
    row_t t[$]; bnd_t e; logic [4:0] m5;
    t.push_back(nop(0));
    if (funct_case) t.push_back(mk(R, F_BAD, 1, 2, 3, 0, 4'b0000, 1));
    else            t.push_back(mk(BAD, 0, 1, 2, 3, 0, 4'b0000, 1));
    t.push_back(mk(R, F_ADD, 1, 2, 3, 0, 4'b0000, 1));
    t.push_back(nop(1));
    foreach (t[i]) begin
      opcode = t[i].op; funct = t[i].fn; rs = t[i].rs; rt = t[i].rt; rd = t[i].rd;
      operands_eq = t[i].eq;
      #2;
      n_cmp++;
      if ({stall, pc_src, if_flush} !== t[i].cmb) begin
        n_err++; $display("FAIL illegal comb row %0d: got %b want %b", i, {stall, pc_src, if_flush}, t[i].cmb);
      end
      e = exp_bundle(t[i].op, t[i].fn, t[i].rt, t[i].rd);
      exq.push_back(e); memq.push_back(e); wbq.push_back(e);
      @(posedge clk); #1;
      e = exq.pop_front(); m5 = ex_mask(e); void'(memq.pop_front()); void'(wbq.pop_front());
      n_cmp++;
      if (({ex_valid, ex_alu_src, ex_alu_op} & m5) !== ({e.valid, e.alu_src, e.alu_op} & m5)) begin
        n_err++; $display("FAIL illegal ex row %0d: got %b want %b", i, {ex_valid, ex_alu_src, ex_alu_op}, {e.valid, e.alu_src, e.alu_op});
      end
      n_cmp++;
      if (illegal !== t[i].ill) begin
        n_err++; $display("FAIL illegal flag row %0d: got %b want %b", i, illegal, t[i].ill);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    row_t t[$]; row_t r; bnd_t e; logic [4:0] m5; logic [6:0] m7; logic [7:0] m8;
    t.push_back(nop(1)); t.push_back(nop(1));
    t.push_back(mk(LW, 0, 1, 5, 0, 0, 4'b0000, 1));
    r = mk(R, F_ADD, 5, 2, 6, 0, 4'b1000, 0); r.rst = 1'b1; t.push_back(r);
    t.push_back(mk(R, F_ADD, 5, 2, 6, 0, 4'b0000, 0));
    repeat (3) t.push_back(nop(0));
    foreach (t[i]) begin
      rst = t[i].rst;
      opcode = t[i].op; funct = t[i].fn; rs = t[i].rs; rt = t[i].rt; rd = t[i].rd;
      operands_eq = t[i].eq;
      #2;
      n_cmp++;
      if ({stall, pc_src, if_flush} !== t[i].cmb) begin
        n_err++; $display("FAIL rst_stall comb row %0d: got %b want %b", i, {stall, pc_src, if_flush}, t[i].cmb);
      end
      e = t[i].cmb[3] ? BUBBLE : exp_bundle(t[i].op, t[i].fn, t[i].rt, t[i].rd);
      if (t[i].rst) begin
        exq.delete(); memq.delete(); wbq.delete();
        exq.push_back(BUBBLE);
        repeat (2) memq.push_back(BUBBLE);
        repeat (3) wbq.push_back(BUBBLE);
      end else begin
        exq.push_back(e); memq.push_back(e); wbq.push_back(e);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      e = exq.pop_front(); m5 = ex_mask(e); n_cmp++;
      if (({ex_valid, ex_alu_src, ex_alu_op} & m5) !== ({e.valid, e.alu_src, e.alu_op} & m5)) begin
        n_err++; $display("FAIL rst_stall ex row %0d: got %b want %b", i, {ex_valid, ex_alu_src, ex_alu_op}, {e.valid, e.alu_src, e.alu_op});
      end
      e = memq.pop_front(); m7 = mem_mask(e); n_cmp++;
      if (({mem_read, mem_write, mem_dst} & m7) !== ({e.mr, e.mw, e.dst} & m7)) begin
        n_err++; $display("FAIL rst_stall mem row %0d: got %b want %b", i, {mem_read, mem_write, mem_dst}, {e.mr, e.mw, e.dst});
      end
      e = wbq.pop_front(); m8 = wb_mask(e); n_cmp++;
      if (({wb_reg_write, wb_mem_to_reg, wb_dst} & m8) !== ({e.rw, e.m2r, e.dst} & m8)) begin
        n_err++; $display("FAIL rst_stall wb row %0d: got %b want %b", i, {wb_reg_write, wb_mem_to_reg, wb_dst}, {e.rw, e.m2r, e.dst});
      end
      n_cmp++;
      if (illegal !== t[i].ill) begin
        n_err++; $display("FAIL rst_stall illegal row %0d: got %b want %b", i, illegal, t[i].ill);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_use();
    test_branch_hazard();
    test_jumps();
    test_illegal(1'b0);
    test_reset_mid_stall();
    test_illegal(1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
